// File: rtl/shift_register_piso_pkg.sv
// Shared types and defaults for the parallel-in, serial-out shifter.
// Keeps the per-edge operation decode in one place so priority is explicit.
package shift_register_piso_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Operation applied to the register on a clock edge when reset is not active.
  typedef enum logic {
    OP_SHIFT = 1'b0,
    OP_LOAD  = 1'b1
  } op_e;

  function automatic op_e decode_op(input logic load);
    return load ? OP_LOAD : OP_SHIFT;
  endfunction

endpackage

// File: rtl/shift_register_piso.sv
// Parallel-in, serial-out shift register: captures a word on load, then emits
// one bit per clock from the head of the register, zero-filling behind it.
module shift_register_piso
  import shift_register_piso_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic             out
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] shifted;
  op_e              op;

  assign op = decode_op(load);

  // Direction is fixed at elaboration; the head bit is the one that leaves next.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign shifted = {1'b0, q_q[WIDTH-1:1]};
      assign out     = q_q[0];
    end else begin : g_msb_first
      assign shifted = {q_q[WIDTH-2:0], 1'b0};
      assign out     = q_q[WIDTH-1];
    end
  endgenerate

  always_comb begin
    // NOTE: default assignment first so every path drives q_d and no latch is inferred.
    q_d = q_q;
    unique case (op)
      OP_LOAD:  q_d = in;
      OP_SHIFT: q_d = shifted;
      default:  q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for state so all flops update together at the edge.
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: tb/tb_shift_register_piso.sv
// Randomised scoreboard bench for shift_register_piso, running an LSB-first and
// an MSB-first instance side by side on the same stimulus.
module tb_shift_register_piso;

  localparam int W = 8;

  typedef struct {
    logic exp_lsb;
    logic exp_msb;
    int   phase;
    int   seq;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in;
  logic         load;
  logic         out_lsb;
  logic         out_msb;

  exp_t sb_q[$];
  int   n_compared;
  int   n_mismatched;
  int   seq_num;

  // Reference model: the last captured word and how many bits have been sent since.
  logic [W-1:0] word_m;
  int           sent_m;

  shift_register_piso #(.WIDTH(W), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .load  (load),
    .out   (out_lsb)
  );

  shift_register_piso #(.WIDTH(W), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .load  (load),
    .out   (out_msb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int phase, input int seq,
                       input logic actual, input logic expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s phase=%0d seq=%0d actual=%b expected=%b",
               name, phase, seq, actual, expected);
    end
  endtask

  // Drive one edge's worth of inputs, advance the model, queue the expected outputs.
  task automatic step(input logic r, input logic l, input logic [W-1:0] d, input int phase);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    load  = l;
    in    = d;
    if (!r) begin
      word_m = '0;
      sent_m = 0;
    end else if (l) begin
      word_m = d;
      sent_m = 0;
    end else begin
      sent_m++;
    end
    e.exp_lsb = (sent_m < W) ? word_m[sent_m] : 1'b0;
    e.exp_msb = (sent_m < W) ? word_m[W-1-sent_m] : 1'b0;
    e.phase   = phase;
    e.seq     = seq_num++;
    sb_q.push_back(e);
  endtask

  // Monitor: output is presented every cycle, so pop one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("out_lsb_first", e.phase, e.seq, out_lsb, e.exp_lsb);
        check("out_msb_first", e.phase, e.seq, out_msb, e.exp_msb);
      end
    end
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    seq_num      = 0;
    word_m       = '0;
    sent_m       = 0;
    rst_n        = 1'b0;
    load         = 1'b1;
    in           = 8'hFF;

    // Phase 1: reset beats load for two edges.
    repeat (2) step(1'b0, 1'b1, 8'hFF, 1);

    // Phase 2: single-edge load of 10010110, then let it drain and idle.
    step(1'b1, 1'b1, 8'b1001_0110, 2);
    repeat (W + 4) step(1'b1, 1'b0, $urandom, 2);

    // Phase 3: reload mid-stream.
    step(1'b1, 1'b1, 8'hF0, 3);
    repeat (3) step(1'b1, 1'b0, 8'h00, 3);
    step(1'b1, 1'b1, 8'h0F, 3);
    repeat (W + 1) step(1'b1, 1'b0, 8'hAA, 3);

    // Phase 4: load held high across several edges, data changing underneath.
    repeat (4) step(1'b1, 1'b1, 8'h01, 4);
    repeat (2) step(1'b1, 1'b1, 8'h02, 4);
    repeat (3) step(1'b1, 1'b0, 8'h02, 4);

    // Phase 5: reset mid-stream, then idle until the next load.
    step(1'b1, 1'b1, 8'hFF, 5);
    repeat (2) step(1'b1, 1'b0, 8'h00, 5);
    step(1'b0, 1'b0, 8'h00, 5);
    repeat (4) step(1'b1, 1'b0, 8'hFF, 5);

    // Phase 6: random traffic with occasional loads and resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 5) == 0), W'($urandom), 6);
    end

    // Drain the scoreboard, bounded by a fixed number of edges.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    n_compared++;
    if (sb_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0 pending", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
